cache_port_arbiter: RTL

Round-robin arbiter sharing the single CPU-side cache port between two requesters (port 0 and port 1, e.g. instruction fetch and data access). Each requester drives a Req/Wr/address/data/Ins_Type bundle; the arbiter grants one, latches its fields onto the cache port, waits for `Ready_Cache`, then returns read data and a one-cycle ready pulse to the owner. A per-transaction timeout aborts a hung cache access with an error flag.

---
 rtl/cache_port_arbiter_if.sv | 35 +++
 rtl/cache_port_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/cache_port_arbiter_if.sv
// Bundle of the two requester ports plus the shared CPU-side cache port.
// The slave modport is the arbiter's view. The master modport is the view
// of whatever drives the requests and models the cache.
interface cache_port_arbiter_if;
    logic        Req_0, Req_1;
    logic        Wr_0, Wr_1;
    logic [31:0] A_0, A_1;
    logic [31:0] wdata_0, wdata_1;
    logic [1:0]  Ins_Type_0, Ins_Type_1;
    logic        Ready_0, Ready_1;
    logic [31:0] rdata_0, rdata_1;
    logic        Err_0, Err_1;
    logic        Req_CPU;
    logic        Wr_CPU;
    logic [31:0] A_CPU;
    logic [31:0] data_out;
    logic [1:0]  Ins_Type;
    logic        Ready_Cache;
    logic [31:0] data_in;
    logic        Busy;

    modport slave (
        input  Req_0, Req_1, Wr_0, Wr_1, A_0, A_1, wdata_0, wdata_1,
               Ins_Type_0, Ins_Type_1, Ready_Cache, data_in,
        output Ready_0, Ready_1, rdata_0, rdata_1, Err_0, Err_1,
               Req_CPU, Wr_CPU, A_CPU, data_out, Ins_Type, Busy
    );

    modport master (
        output Req_0, Req_1, Wr_0, Wr_1, A_0, A_1, wdata_0, wdata_1,
               Ins_Type_0, Ins_Type_1, Ready_Cache, data_in,
        input  Ready_0, Ready_1, rdata_0, rdata_1, Err_0, Err_1,
               Req_CPU, Wr_CPU, A_CPU, data_out, Ins_Type, Busy
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter for two requesters sharing one cache port.
// A transaction runs IDLE -> ISSUE -> RESP. ISSUE ends either on Ready_Cache
// or on a timeout abort, which returns zero data with Err set.
module cache_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input logic                 clk,
    input logic                 rst,
    cache_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic [TO_W-1:0] cnt;
    logic            pick;

    // On a tie, the port that did not win last time is granted. Otherwise the
    // grant goes to whichever port is requesting.
    always_comb begin
        pick = bus.Req_1;
        if (bus.Req_0 && bus.Req_1) pick = ~last_grant;
    end

    // Transaction FSM. All outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            bus.Req_CPU  <= 1'b0;
            bus.Wr_CPU   <= 1'b0;
            bus.A_CPU    <= '0;
            bus.data_out <= '0;
            bus.Ins_Type <= '0;
            bus.Ready_0  <= 1'b0;
            bus.Ready_1  <= 1'b0;
            bus.rdata_0  <= '0;
            bus.rdata_1  <= '0;
            bus.Err_0    <= 1'b0;
            bus.Err_1    <= 1'b0;
            bus.Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Req_0 || bus.Req_1) begin
                        owner        <= pick;
                        last_grant   <= pick;
                        cnt          <= '0;
                        bus.Req_CPU  <= 1'b1;
                        bus.Busy     <= 1'b1;
                        bus.Wr_CPU   <= pick ? bus.Wr_1       : bus.Wr_0;
                        bus.A_CPU    <= pick ? bus.A_1        : bus.A_0;
                        bus.data_out <= pick ? bus.wdata_1    : bus.wdata_0;
                        bus.Ins_Type <= pick ? bus.Ins_Type_1 : bus.Ins_Type_0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Completion is checked first so that it wins over a
                    // timeout that expires in the same cycle.
                    if (bus.Ready_Cache) begin
                        bus.Req_CPU <= 1'b0;
                        if (owner) begin
                            bus.rdata_1 <= bus.data_in;
                            bus.Ready_1 <= 1'b1;
                            bus.Err_1   <= 1'b0;
                        end else begin
                            bus.rdata_0 <= bus.data_in;
                            bus.Ready_0 <= 1'b1;
                            bus.Err_0   <= 1'b0;
                        end
                        state <= RESP;
                    end else if (cnt == TERM) begin
                        bus.Req_CPU <= 1'b0;
                        if (owner) begin
                            bus.rdata_1 <= '0;
                            bus.Ready_1 <= 1'b1;
                            bus.Err_1   <= 1'b1;
                        end else begin
                            bus.rdata_0 <= '0;
                            bus.Ready_0 <= 1'b1;
                            bus.Err_0   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (owner) begin
                        bus.Ready_1 <= 1'b0;
                        bus.Err_1   <= 1'b0;
                    end else begin
                        bus.Ready_0 <= 1'b0;
                        bus.Err_0   <= 1'b0;
                    end
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
